// File: rtl/ht_filter_controller_if.sv
// ht_filter_controller_if -- control/coefficient bus between the filter
// controller and its surroundings (coefficient source, tap RAM, filter MAC).
//   master : controller side (drives enables, write strobe, status)
//   slave  : environment side (drives start/stop/reload, coefficient stream)
//   sample_strobe : sampleValid & sampleReady, the filter's sample accept
interface ht_filter_controller_if #(
  parameter int DATA_WIDTH = 18
);
  logic                         start;
  logic                         stop;
  logic                         reload;
  logic                         coeffSetFlag;
  logic signed [DATA_WIDTH-1:0] coeffIn;
  logic                         sampleValid;
  logic                         coeffEnable;
  logic                         coeffWrite;
  logic [9:0]                   coeffAddr;
  logic signed [DATA_WIDTH-1:0] coeffData;
  logic                         filterEnable;
  logic                         sampleReady;
  logic                         flushValid;
  logic                         busy;
  logic                         error;
  logic [2:0]                   state;
  logic                         sample_strobe;

  assign sample_strobe = sampleValid & sampleReady;

  modport master (
    input  start, stop, reload, coeffSetFlag, coeffIn, sampleValid,
    output coeffEnable, coeffWrite, coeffAddr, coeffData, filterEnable,
           sampleReady, flushValid, busy, error, state
  );

  modport slave (
    output start, stop, reload, coeffSetFlag, coeffIn, sampleValid,
    input  coeffEnable, coeffWrite, coeffAddr, coeffData, filterEnable,
           sampleReady, flushValid, busy, error, state, sample_strobe
  );
endinterface

// File: rtl/ht_filter_controller.sv
// ht_filter_controller -- sequences coefficient loading and filter run/flush.
//   clock  : rising-edge clock
//   reset  : asynchronous active-high reset
//   bus    : ht_filter_controller_if.master
//     in : start/stop/reload pulses, coeffSetFlag + coeffIn stream, sampleValid
//     out: coeffEnable, coeffWrite/coeffAddr/coeffData tap writes,
//          filterEnable, sampleReady, flushValid, busy, sticky error, state
// Flow: IDLE -start-> PRIME (1 cycle, source latency) -> LOAD (one tap per
// cycle) -> RUN -> FLUSH (LENGTH-1 zero samples) -> IDLE or PRIME (reload).
// All outputs are registered and decoded from the next state so they line
// up exactly with the state register.
module ht_filter_controller #(
  parameter int LENGTH     = 27,
  parameter int DATA_WIDTH = 18,
  parameter int TIMEOUT    = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  ht_filter_controller_if.master bus
);
  localparam int LT = LENGTH + TIMEOUT;
  localparam int CW = $clog2(LT + 1);
  localparam int FW = $clog2(LENGTH + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRIME = 3'd1,
    LOAD  = 3'd2,
    RUN   = 3'd3,
    FLUSH = 3'd4,
    ERR   = 3'd5
  } state_t;

  state_t                       st_q, st_n;
  logic [CW-1:0]                idx_q;     // LOAD cycle count == tap index
  logic [FW-1:0]                fcnt_q;    // FLUSH cycle count
  logic                         reload_q;  // FLUSH exits to PRIME
  logic                         wr_n;
  logic                         ce_q, wr_q, fe_q, rdy_q, fv_q, busy_q, err_q;
  logic [9:0]                   addr_q;
  logic signed [DATA_WIDTH-1:0] data_q;
  logic                         in_range, is_last, at_timeout, flush_done;

  assign in_range   = idx_q < CW'(LENGTH);
  assign is_last    = idx_q == CW'(LENGTH - 1);
  assign at_timeout = idx_q == CW'(LT - 1);
  // Unused when LENGTH==1: RUN then bypasses FLUSH entirely.
  assign flush_done = fcnt_q == FW'(LENGTH - 2);

  always_comb begin
    st_n = st_q;
    wr_n = 1'b0;
    case (st_q)
      IDLE:  if (bus.start) st_n = PRIME;
      PRIME: st_n = bus.stop ? IDLE : LOAD;
      LOAD: begin
        if (bus.stop) begin
          st_n = IDLE;
        end else if (bus.coeffSetFlag) begin
          // early/late flag is a source fault; the offending tap is not written
          if (is_last) begin
            st_n = RUN;
            wr_n = 1'b1;
          end else begin
            st_n = ERR;
          end
        end else begin
          // keep sampling past LENGTH for the timeout, but never write there
          wr_n = in_range;
          if (at_timeout) st_n = ERR;
        end
      end
      RUN: begin
        if (bus.stop || bus.reload) begin
          if (LENGTH == 1) st_n = bus.stop ? IDLE : PRIME;
          else             st_n = FLUSH;
        end
      end
      FLUSH: if (flush_done) st_n = reload_q ? PRIME : IDLE;
      ERR:   st_n = ERR;
      default: st_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st_q     <= IDLE;
      idx_q    <= '0;
      fcnt_q   <= '0;
      reload_q <= 1'b0;
      ce_q     <= 1'b0;
      wr_q     <= 1'b0;
      fe_q     <= 1'b0;
      rdy_q    <= 1'b0;
      fv_q     <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      st_q   <= st_n;
      ce_q   <= (st_n == PRIME) || (st_n == LOAD);
      fe_q   <= (st_n == RUN) || (st_n == FLUSH);
      rdy_q  <= st_n == RUN;
      fv_q   <= st_n == FLUSH;
      busy_q <= st_n != IDLE;
      if (st_n == ERR) err_q <= 1'b1;
      wr_q   <= wr_n;
      if (wr_n) begin
        data_q <= bus.coeffIn;
        addr_q <= 10'(idx_q);
      end
      idx_q  <= (st_q == LOAD)  ? idx_q + CW'(1)  : '0;
      fcnt_q <= (st_q == FLUSH) ? fcnt_q + FW'(1) : '0;
      if (st_q == RUN) reload_q <= bus.reload && !bus.stop;
    end
  end

  assign bus.coeffEnable  = ce_q;
  assign bus.coeffWrite   = wr_q;
  assign bus.coeffAddr    = addr_q;
  assign bus.coeffData    = data_q;
  assign bus.filterEnable = fe_q;
  assign bus.sampleReady  = rdy_q;
  assign bus.flushValid   = fv_q;
  assign bus.busy         = busy_q;
  assign bus.error        = err_q;
  assign bus.state        = st_q;
endmodule

// File: tb/tb_ht_filter_controller.sv
// tb_ht_filter_controller -- scoreboard bench: a coefficient source model
// pushes each tap it presents (that should land) into a queue; a write
// monitor pops and compares every coeffWrite. Control-flow checks run in
// the main thread, sampled 1 time unit after the falling edge.
module tb_ht_filter_controller;
  localparam int LENGTH = 27, DATA_WIDTH = 18, TIMEOUT = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  ht_filter_controller_if #(.DATA_WIDTH(DATA_WIDTH)) ifc();

  ht_filter_controller #(
    .LENGTH(LENGTH), .DATA_WIDTH(DATA_WIDTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(ifc)
  );

  typedef struct packed {
    logic [9:0]        addr;
    logic signed [17:0] data;
  } wr_t;

  wr_t sb[$];
  wr_t e;
  int  ncmp = 0, nerr = 0, nwr = 0;
  int  flag_idx = LENGTH - 1;
  int  sk = 0;
  bit  sstart = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic signed [17:0] coef(input int k);
    return 18'(k * 50 / 26 - 25);
  endfunction

  // Source: one cycle of latency after coeffEnable rises, then one
  // coefficient per cycle; flag raised with tap flag_idx (<0: never).
  always @(negedge clock) begin
    if (ifc.coeffEnable) begin
      if (sstart) begin
        ifc.coeffIn      = coef(sk);
        ifc.coeffSetFlag = (sk == flag_idx);
        if (sk < LENGTH && (flag_idx < 0 || sk < flag_idx || flag_idx == LENGTH - 1))
          sb.push_back({10'(sk), coef(sk)});
        sk++;
      end else begin
        sstart = 1'b1;
      end
    end else begin
      sstart           = 1'b0;
      sk               = 0;
      ifc.coeffIn      = '0;
      ifc.coeffSetFlag = 1'b0;
    end
  end

  always @(negedge clock) begin
    if (ifc.coeffWrite) begin
      nwr++;
      if (sb.size() == 0) begin
        chk("wr_extra", {4'b0, ifc.coeffAddr, ifc.coeffData}, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("wr", {4'b0, ifc.coeffAddr, ifc.coeffData}, {4'b0, e.addr, e.data});
      end
    end
  end

  function automatic logic [9:0] outs();
    return {ifc.coeffEnable, ifc.coeffWrite, ifc.filterEnable, ifc.sampleReady,
            ifc.flushValid, ifc.busy, ifc.error, ifc.state};
  endfunction

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(negedge clock);
      #1;
    end
  endtask

  task automatic pulse(input bit s, input bit p, input bit r);
    ifc.start = s; ifc.stop = p; ifc.reload = r;
    cyc();
    ifc.start = 1'b0; ifc.stop = 1'b0; ifc.reload = 1'b0;
  endtask

  task automatic wait_st(input logic [2:0] s, input int max, input string tag);
    int n = 0;
    while (ifc.state !== s && n < max) begin
      cyc();
      n++;
    end
    chk(tag, ifc.state, s);
  endtask

  task automatic wait_wr(input int target, input int max, input string tag);
    int n = 0;
    while (nwr < target && n < max) begin
      cyc();
      n++;
    end
    chk(tag, nwr, target);
  endtask

  task automatic flush_check(input string tag, input logic [2:0] after);
    int n = 0, bad = 0;
    while (ifc.state == 3'd4 && n < 100) begin
      if (ifc.sampleReady || !ifc.filterEnable || !ifc.flushValid) bad++;
      n++;
      cyc();
    end
    chk({tag, "_len"}, n, LENGTH - 1);
    chk({tag, "_sig"}, bad, 0);
    chk({tag, "_next"}, ifc.state, after);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n0, n1, nl;
    ifc.start = 1'b0; ifc.stop = 1'b0; ifc.reload = 1'b0; ifc.sampleValid = 1'b0;
    cyc(2);
    chk("rst_outs", outs(), 10'd0);
    chk("rst_addr", ifc.coeffAddr, 10'd0);
    chk("rst_data", ifc.coeffData, 18'd0);
    reset = 1'b0;
    cyc();
    pulse(0, 1, 1);
    chk("idle_ignore", {ifc.state, ifc.busy}, 4'd0);

    // conforming load
    ifc.sampleValid = 1'b1;
    flag_idx = LENGTH - 1;
    n0 = nwr;
    pulse(1, 0, 0);
    chk("prime", {ifc.state, ifc.coeffEnable}, {3'd1, 1'b1});
    cyc();
    chk("load_entry", {ifc.state, ifc.coeffWrite, ifc.coeffAddr}, {3'd2, 1'b0, 10'd0});
    cyc();
    chk("first_wr", {ifc.coeffWrite, ifc.coeffAddr}, {1'b1, 10'd0});
    pulse(1, 0, 0);
    wait_st(3'd3, 60, "run_a");
    cyc();
    chk("run_a_wr", nwr - n0, LENGTH);
    chk("run_a_outs", outs(), {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd3});
    chk("strobe", ifc.sample_strobe, 1'b1);
    chk("sb_a", sb.size(), 0);

    // reload while running
    n0 = nwr;
    pulse(0, 0, 1);
    flush_check("reload", 3'd1);
    chk("reload_ce", ifc.coeffEnable, 1'b1);
    wait_st(3'd3, 60, "run_b");
    cyc();
    chk("reload_wr", nwr - n0, LENGTH);
    chk("sb_b", sb.size(), 0);

    // stop and reload together: stop wins
    pulse(0, 1, 1);
    flush_check("stop", 3'd0);
    chk("stop_busy", ifc.busy, 1'b0);

    // abort mid-load
    n0 = nwr;
    pulse(1, 0, 0);
    wait_wr(n0 + 5, 40, "abort_pre");
    n1 = nwr;
    pulse(0, 1, 0);
    chk("abort", {ifc.state, ifc.coeffEnable, ifc.busy}, 5'd0);
    sb.delete();
    cyc(5);
    chk("abort_nowr", nwr - n1, 0);

    // flag too early
    flag_idx = 20;
    n0 = nwr;
    pulse(1, 0, 0);
    wait_st(3'd5, 60, "err_state");
    chk("err_outs", outs(), {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd5});
    chk("err_wr", nwr - n0, 20);
    chk("sb_err", sb.size(), 0);
    pulse(1, 1, 1);
    cyc(3);
    chk("err_sticky", {ifc.error, ifc.state}, {1'b1, 3'd5});
    reset = 1'b1;
    cyc();
    chk("err_cleared", {ifc.error, ifc.state}, 4'd0);
    reset = 1'b0;
    cyc();

    // flag never arrives
    flag_idx = -1;
    n0 = nwr;
    pulse(1, 0, 0);
    cyc();
    nl = 0;
    while (ifc.state == 3'd2 && nl < 100) begin
      nl++;
      cyc();
    end
    chk("to_cycles", nl, LENGTH + TIMEOUT);
    chk("to_state", ifc.state, 3'd5);
    chk("to_wr", nwr - n0, LENGTH);
    chk("sb_to", sb.size(), 0);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    cyc();

    // reset in the middle of a load
    flag_idx = LENGTH - 1;
    n0 = nwr;
    pulse(1, 0, 0);
    wait_wr(n0 + 10, 40, "rstmid_pre");
    chk("rstmid_addr", ifc.coeffAddr, 10'd9);
    reset = 1'b1;
    #1;
    chk("rstmid_outs", outs(), 10'd0);
    chk("rstmid_ad", {ifc.coeffAddr, ifc.coeffData}, 28'd0);
    sb.delete();
    n1 = nwr;
    cyc(2);
    reset = 1'b0;
    cyc(5);
    chk("rstmid_nowr", nwr - n1, 0);
    chk("rstmid_state", ifc.state, 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/ht_filter_controller.md
HT_FILTER_CONTROLLER -- requirements
Module: ht_filter_controller

Interface
REQ-001 SHALL have parameter LENGTH, default 27, giving the number of filter taps/coefficients (1..1023).
REQ-002 SHALL have parameter DATA_WIDTH, default 18, giving the coefficient width in bits.
REQ-003 SHALL have parameter TIMEOUT, default 8, giving the extra cycles beyond LENGTH allowed for coefficient setup.
REQ-004 SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port start, input, 1, a pulse requesting a coefficient load followed by filtering.
REQ-007 SHALL have port stop, input, 1, a pulse requesting flush and return to idle.
REQ-008 SHALL have port reload, input, 1, a pulse requesting flush then coefficient reload while running.
REQ-009 SHALL have port coeffSetFlag, input, 1, the last-coefficient flag from the coefficient source.
REQ-010 SHALL have port coeffIn, input, DATA_WIDTH signed, the coefficient stream from the source.
REQ-011 SHALL have port sampleValid, input, 1, upstream sample-valid.
REQ-012 SHALL have port coeffEnable, output, 1, the enable to the coefficient source.
REQ-013 SHALL have port coeffWrite, output, 1, the tap-register write strobe.
REQ-014 SHALL have port coeffAddr, output, 10, the tap index for coeffWrite.
REQ-015 SHALL have port coeffData, output, DATA_WIDTH signed, the registered copy of coeffIn.
REQ-016 SHALL have port filterEnable, output, 1, which enables filter MAC operation.
REQ-017 SHALL have port sampleReady, output, 1, upstream ready.
REQ-018 SHALL have port flushValid, output, 1, which injects a zero sample into the filter.
REQ-019 SHALL have port busy, output, 1, asserted in any non-IDLE state.
REQ-020 SHALL have port error, output, 1, a sticky setup fault.
REQ-021 SHALL have port state, output, 3, the current state encoding.

Function
REQ-022 SHALL implement states IDLE=0, PRIME=1, LOAD=2, RUN=3, FLUSH=4 and ERR=5, all registered.
REQ-023 SHALL, in IDLE, move to PRIME on start with coeffEnable=1 from the next cycle; stop and reload are ignored in IDLE.
REQ-024 SHALL spend exactly 1 cycle in PRIME (coeffIn not yet valid), then move to LOAD with coeffAddr=0.
REQ-025 SHALL, in LOAD, each cycle register coeffIn into coeffData, pulse coeffWrite with coeffAddr equal to the tap index, then increment coeffAddr; write k lands one cycle after sampling, so the first write occurs 3 cycles after start.
REQ-026 SHALL, when coeffSetFlag=1 in LOAD with index == LENGTH-1, capture the final coefficient, deassert coeffEnable, and enter RUN.
REQ-027 SHALL enter ERR when coeffSetFlag=1 with index != LENGTH-1, or when no flag has arrived after LENGTH+TIMEOUT LOAD cycles.
REQ-028 SHALL, in ERR, set error=1 (sticky) and hold coeffEnable=0, filterEnable=0 and sampleReady=0; only reset leaves ERR.
REQ-029 SHALL, in RUN, set filterEnable=1 and sampleReady=1; the sampleValid&sampleReady handshake is the filter's sample strobe.
REQ-030 SHALL, on stop or reload in RUN, enter FLUSH; if both are asserted in the same cycle, stop wins.
REQ-031 SHALL, in FLUSH, hold sampleReady=0, filterEnable=1 and flushValid=1 for exactly LENGTH-1 cycles, then go to IDLE (stop) or PRIME (reload).
REQ-032 SHALL treat start during LOAD, FLUSH or PRIME as ignored, and stop during PRIME or LOAD as abort to IDLE with coeffEnable=0 and no further writes.
REQ-033 SHALL, on a coeffAddr overflow guard, prevent LOAD from writing index >= LENGTH.

Reset
REQ-034 SHALL, on reset, asynchronously set state=IDLE and all outputs to 0, including coeffData, coeffAddr and error, and clear all counters.
REQ-035 SHALL abort reset mid-LOAD or mid-FLUSH immediately, with no further coeffWrite.

Verification
REQ-036 SHALL cover this scenario: start pulse with a conforming source (LENGTH=27, coefficients -25..25) -> 27 coeffWrite pulses at addr 0..26 with data matching, RUN entered, coeffEnable low.
REQ-037 SHALL cover this scenario: source asserting coeffSetFlag at index 20 -> ERR, error=1, and error stays 1 until reset.
REQ-038 SHALL cover this scenario: source never asserting the flag -> ERR after 35 LOAD cycles.
REQ-039 SHALL cover this scenario: reload in RUN -> 26 flushValid cycles, sampleReady=0, then PRIME and a full 27-write reload.
REQ-040 SHALL cover this scenario: stop and reload asserted in the same RUN cycle -> 26 flush cycles, then IDLE and busy=0.
REQ-041 SHALL cover this scenario: reset asserted at LOAD index 10 -> all outputs 0 at once, state=0, and no write afterwards.
